desk_call_scheduler: RTL and testbench

//   Shares the ticket-call resource of the response system among NUM_DESKS service desks.

---
 rtl/desk_call_scheduler.sv | 116 +++++++++++
 tb/tb_desk_call_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/desk_call_scheduler.sv
// desk_call_scheduler: round-robin arbiter handing out service numbers to desks,
// tracking waiting tickets and holding each announcement for CALL_CYCLES clocks.
module desk_call_scheduler #(
    parameter int NUM_DESKS   = 3,
    parameter int DESK_W      = 2,
    parameter int NUM_W       = 4,
    parameter int TICKET_MAX  = 14,
    parameter int CALL_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ticket_take,
    input  logic [NUM_DESKS-1:0]       desk_req,
    output logic                       call_valid,
    output logic [DESK_W-1:0]          call_desk,
    output logic [NUM_W-1:0]           call_number,
    output logic                       call_active,
    output logic [NUM_DESKS*NUM_W-1:0] desk_number,
    output logic [NUM_W-1:0]           waiting,
    output logic                       ticket_reject
);
    localparam int CNT_W = (CALL_CYCLES > 1) ? $clog2(CALL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, ANNOUNCE} state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [NUM_DESKS-1:0]       pending_q, pending_d, win_oh;
    logic [DESK_W-1:0]          rr_ptr_q, rr_ptr_d, win, idx;
    logic [NUM_W-1:0]           serve_q, serve_d, waiting_q, waiting_d, call_number_q;
    logic [DESK_W-1:0]          call_desk_q;
    logic [NUM_DESKS*NUM_W-1:0] desk_number_q;
    logic                       call_valid_q, call_active_q, reject_q, reject_d;
    logic                       grant, full, found;

    assign grant = (state_q == GRANT);
    assign full  = (waiting_q == NUM_W'(TICKET_MAX));

    // Cyclic search for the first pending desk starting at rr_ptr.
    always_comb begin
        win   = rr_ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_DESKS; k++) begin
            idx = DESK_W'((int'(rr_ptr_q) + k) % NUM_DESKS);
            if (!found && pending_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // A take at the limit is only accepted when a grant frees a slot on the same edge.
    always_comb begin
        win_oh    = NUM_DESKS'(1) << win;
        pending_d = (pending_q & ~(grant ? win_oh : '0)) | desk_req;
        rr_ptr_d  = (win == DESK_W'(NUM_DESKS - 1)) ? '0 : win + 1'b1;
        serve_d   = (serve_q == NUM_W'(TICKET_MAX)) ? NUM_W'(1) : serve_q + 1'b1;
        reject_d  = ticket_take && full && !grant;
        waiting_d = (ticket_take && !grant && !full) ? waiting_q + 1'b1 :
                    (!ticket_take && grant)          ? waiting_q - 1'b1 : waiting_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            serve_q       <= '0;
            waiting_q     <= '0;
            reject_q      <= 1'b0;
            call_valid_q  <= 1'b0;
            call_active_q <= 1'b0;
            call_desk_q   <= '0;
            call_number_q <= '0;
            desk_number_q <= '0;
        end else begin
            pending_q    <= pending_d;
            waiting_q    <= waiting_d;
            reject_q     <= reject_d;
            call_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (|pending_q && waiting_q != '0) state_q <= GRANT;
                GRANT: begin
                    serve_q                              <= serve_d;
                    call_number_q                        <= serve_d;
                    desk_number_q[win*NUM_W +: NUM_W]    <= serve_d;
                    call_desk_q                          <= win;
                    call_valid_q                         <= 1'b1;
                    call_active_q                        <= 1'b1;
                    rr_ptr_q                             <= rr_ptr_d;
                    cnt_q                                <= '0;
                    state_q                              <= ANNOUNCE;
                end
                ANNOUNCE: begin
                    if (cnt_q == CNT_W'(CALL_CYCLES - 1)) begin
                        state_q       <= IDLE;
                        call_active_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign call_valid    = call_valid_q;
    assign call_desk     = call_desk_q;
    assign call_number   = call_number_q;
    assign call_active   = call_active_q;
    assign desk_number   = desk_number_q;
    assign waiting       = waiting_q;
    assign ticket_reject = reject_q;
endmodule

// File: tb/tb_desk_call_scheduler.sv
// tb_desk_call_scheduler: directed checks of ticket counting, round-robin calls,
// announcement timing, number wrap and ticket rejection.
module tb_desk_call_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ticket_take = 1'b0;
    logic [2:0]  desk_req = 3'b000;
    logic        call_valid, call_active, ticket_reject;
    logic [1:0]  call_desk;
    logic [3:0]  call_number, waiting;
    logic [11:0] desk_number;

    int total = 0;
    int passed = 0;
    int n;
    int cnt;

    desk_call_scheduler dut (
        .clk(clk), .rst(rst), .ticket_take(ticket_take), .desk_req(desk_req),
        .call_valid(call_valid), .call_desk(call_desk), .call_number(call_number),
        .call_active(call_active), .desk_number(desk_number), .waiting(waiting),
        .ticket_reject(ticket_reject)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_call(output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!call_valid && steps < 20);
    endtask

    task automatic finish_announce();
        int s;
        s = 0;
        while (call_active && s < 20) begin
            step();
            s++;
        end
        chk("announce_end", int'(call_active), 0);
    endtask

    function automatic int desk_num(input int d);
        return int'(desk_number[d*4 +: 4]);
    endfunction

    initial begin
        step();
        step();
        chk("rst_valid", int'(call_valid), 0);
        chk("rst_active", int'(call_active), 0);
        chk("rst_waiting", int'(waiting), 0);
        chk("rst_desknum", int'(desk_number), 0);
        rst = 1'b0;

        // single ticket then desk 1 request
        ticket_take = 1'b1;
        step();
        ticket_take = 1'b0;
        chk("t2_wait1", int'(waiting), 1);
        desk_req = 3'b010;
        step();
        desk_req = 3'b000;
        chk("t2_novalid_e0", int'(call_valid), 0);
        wait_call(n);
        chk("t2_latency", n, 2);
        chk("t2_desk", int'(call_desk), 1);
        chk("t2_number", int'(call_number), 1);
        chk("t2_desknum1", desk_num(1), 1);
        chk("t2_wait0", int'(waiting), 0);
        chk("t2_active", int'(call_active), 1);
        step();
        chk("t2_valid_pulse", int'(call_valid), 0);
        finish_announce();
        chk("t2_hold_number", int'(call_number), 1);

        // reset in the middle of an announcement, with requests pending
        ticket_take = 1'b1;
        desk_req = 3'b100;
        step();
        ticket_take = 1'b0;
        desk_req = 3'b000;
        wait_call(n);
        chk("t1_call_desk", int'(call_desk), 2);
        chk("t1_call_num", int'(call_number), 2);
        desk_req = 3'b011;
        step();
        desk_req = 3'b000;
        rst = 1'b1;
        #1;
        chk("t1_async_active", int'(call_active), 0);
        chk("t1_async_number", int'(call_number), 0);
        chk("t1_async_desk", int'(call_desk), 0);
        chk("t1_async_desknum", int'(desk_number), 0);
        step();
        rst = 1'b0;
        ticket_take = 1'b1;
        step();
        ticket_take = 1'b0;
        chk("t1_wait1", int'(waiting), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (call_valid) cnt++;
        end
        chk("t1_pending_lost", cnt, 0);

        // three grants from one simultaneous request
        ticket_take = 1'b1;
        step();
        step();
        ticket_take = 1'b0;
        chk("t3_wait3", int'(waiting), 3);
        desk_req = 3'b111;
        step();
        desk_req = 3'b000;
        wait_call(n);
        chk("t3_lat", n, 2);
        chk("t3_desk0", int'(call_desk), 0);
        chk("t3_num1", int'(call_number), 1);
        for (int c = 1; c < 3; c++) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (call_active) cnt++;
                step();
            end
            chk("t3_active_len", cnt, 4);
            chk("t3_active_drop", int'(call_active), 0);
            wait_call(n);
            chk("t3_spacing", n + 4, 6);
            chk("t3_desk", int'(call_desk), c);
            chk("t3_num", int'(call_number), c + 1);
        end
        chk("t3_desknum0", desk_num(0), 1);
        chk("t3_desknum2", desk_num(2), 3);
        chk("t3_wait0", int'(waiting), 0);
        finish_announce();

        // request parked while no tickets wait
        desk_req = 3'b001;
        step();
        desk_req = 3'b000;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (call_valid) cnt++;
        end
        chk("t4_no_call", cnt, 0);
        ticket_take = 1'b1;
        step();
        ticket_take = 1'b0;
        chk("t4_wait1", int'(waiting), 1);
        wait_call(n);
        chk("t4_lat", n, 2);
        chk("t4_desk", int'(call_desk), 0);
        chk("t4_num", int'(call_number), 4);
        finish_announce();

        // number wrap after TICKET_MAX
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ticket_take = 1'b1;
            desk_req = 3'(1 << (i % 3));
            step();
            ticket_take = 1'b0;
            desk_req = 3'b000;
            wait_call(n);
            chk("t5_lat", n, 2);
            chk("t5_num", int'(call_number), (i % 14) + 1);
            chk("t5_desk", int'(call_desk), i % 3);
            chk("t5_desknum", desk_num(i % 3), (i % 14) + 1);
            finish_announce();
        end
        chk("t5_wait0", int'(waiting), 0);
        ticket_take = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("t5_wait14", int'(waiting), 14);
        chk("t5_no_reject", int'(ticket_reject), 0);
        step();
        ticket_take = 1'b0;
        chk("t5_reject", int'(ticket_reject), 1);
        chk("t5_wait_held", int'(waiting), 14);
        step();
        chk("t5_reject_pulse", int'(ticket_reject), 0);

        // take on the grant edge at the limit
        desk_req = 3'b001;
        step();
        desk_req = 3'b000;
        step();
        ticket_take = 1'b1;
        step();
        ticket_take = 1'b0;
        chk("t6_valid", int'(call_valid), 1);
        chk("t6_num", int'(call_number), 2);
        chk("t6_wait14", int'(waiting), 14);
        chk("t6_no_reject", int'(ticket_reject), 0);
        finish_announce();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
